// File: rtl/pb_debounce_pkg.sv
// pb_debounce_pkg
// Shared types and limits for the push-button debounce stage.
//   db_state_t     : debounce state machine encoding (2-bit enum)
//   DB_MIN_STABLE  : smallest legal STABLE_CYCLES value
package pb_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } db_state_t;

   localparam int unsigned DB_MIN_STABLE = 2;

endpackage

// File: rtl/pb_debounce_ff_sync2.sv
// ff_sync2
// Two-flop synchronizer for a single asynchronous input bit.
// Reusable by any stage that brings an async level into the clk domain.
// Ports:
//   clk      : sampling clock, rising edge
//   reset_n  : synchronous active-low reset, clears both flops to 0
//   d        : asynchronous input
//   q        : synchronized output (second flop)
module ff_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/pb_debounce.sv
// pb_debounce
// Push-button conditioning: two-flop synchronizer followed by a
// counter-qualified debounce FSM. Produces a clean level and one-cycle
// rise/fall strobes.
// Parameters:
//   STABLE_CYCLES : consecutive disagreeing synchronized samples needed to
//                   change the level (>= DB_MIN_STABLE)
// Ports:
//   clk        : sole clock, rising edge
//   reset_n    : synchronous active-low reset
//   pb_in      : raw asynchronous button input
//   pb_level   : debounced level (registered)
//   rise_pulse : one-cycle strobe on level 0->1 (registered)
//   fall_pulse : one-cycle strobe on level 1->0 (registered); only built
//                when PB_DEBOUNCE_FALL_EN is defined, otherwise tied to 0
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE_LOW  | level is 0, waiting for a 1 sample
// WAIT_HIGH | counting consecutive 1 samples toward a rise
// IDLE_HIGH | level is 1, waiting for a 0 sample
// WAIT_LOW  | counting consecutive 0 samples toward a fall
module pb_debounce
   import pb_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pb_in,
   output logic pb_level,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   generate
      if (STABLE_CYCLES < DB_MIN_STABLE) begin : g_bad_param
         $error("pb_debounce: STABLE_CYCLES must be at least DB_MIN_STABLE");
      end
   endgenerate

   logic s2;

   ff_sync2 u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pb_in),
      .q       (s2)
   );

   db_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
`ifdef PB_DEBOUNCE_FALL_EN
   logic          fall_q, fall_d;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
`ifdef PB_DEBOUNCE_FALL_EN
         fall_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
`ifdef PB_DEBOUNCE_FALL_EN
         fall_q  <= fall_d;
`endif
      end
   end

   // The counter only advances below CNT_LAST, so it can never wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
`ifdef PB_DEBOUNCE_FALL_EN
      fall_d  = 1'b0;
`endif
      case (state_q)
         IDLE_LOW: begin
            cnt_d   = '0;
            level_d = 1'b0;
            if (s2) begin
               state_d = WAIT_HIGH;
               cnt_d   = CW'(1);
            end
         end
         WAIT_HIGH: begin
            if (!s2) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         IDLE_HIGH: begin
            cnt_d   = '0;
            level_d = 1'b1;
            if (!s2) begin
               state_d = WAIT_LOW;
               cnt_d   = CW'(1);
            end
         end
         WAIT_LOW: begin
            if (s2) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
`ifdef PB_DEBOUNCE_FALL_EN
               fall_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign pb_level   = level_q;
   assign rise_pulse = rise_q;
`ifdef PB_DEBOUNCE_FALL_EN
   assign fall_pulse = fall_q;
`else
   assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// tb_pb_debounce
// Bench for pb_debounce with STABLE_CYCLES=4. A run-length model of the
// debounce rule is compared against the DUT after every clock edge;
// directed scenarios pin the model with hand-computed edge counts, then a
// randomized phase exercises arbitrary press/bounce/reset sequences.
module tb_pb_debounce;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic pb_in = 1'b0;
   logic pb_level, rise_pulse, fall_pulse;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rise_cnt = 0, fall_cnt = 0;
   int last_rise = -1, last_fall = -1;

   // model: input delayed by two samples, level, and run length of
   // consecutive delayed samples that disagree with the level
   bit m_d0 = 0, m_d1 = 0;
   bit m_level = 0, m_rise = 0, m_fall = 0;
   int m_run = 0;

   always #5 clk = ~clk;

   pb_debounce #(.STABLE_CYCLES(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pb_in      (pb_in),
      .pb_level   (pb_level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always begin
      bit seen;
      bit exp_fall;
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
         m_d0 = 0; m_d1 = 0; m_level = 0; m_run = 0; m_rise = 0; m_fall = 0;
      end else begin
         seen = m_d1;
         m_rise = 0;
         m_fall = 0;
         if (seen != m_level) begin
            m_run++;
            if (m_run == N) begin
               m_level = seen;
               m_rise = seen;
               m_fall = !seen;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         m_d1 = m_d0;
         m_d0 = pb_in;
      end
`ifdef PB_DEBOUNCE_FALL_EN
      exp_fall = m_fall;
`else
      exp_fall = 1'b0;
`endif
      #1;
      check("model_level", {31'd0, pb_level}, {31'd0, m_level});
      check("model_rise", {31'd0, rise_pulse}, {31'd0, m_rise});
      check("model_fall", {31'd0, fall_pulse}, {31'd0, exp_fall});
      if (rise_pulse === 1'b1) begin rise_cnt++; last_rise = cyc; end
      if (fall_pulse === 1'b1) begin fall_cnt++; last_fall = cyc; end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int start, r0, f0;
      bit pat [4];
      pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[3] = 0;

      // reset held with button pressed, then release
      reset_n = 1'b0;
      pb_in = 1'b1;
      tick(3);
      check("rst_level", {31'd0, pb_level}, 32'd0);
      check("rst_rise", {31'd0, rise_pulse}, 32'd0);
      check("rst_fall", {31'd0, fall_pulse}, 32'd0);
      reset_n = 1'b1;
      start = cyc;
      r0 = rise_cnt;
      tick(8);
      check("rst_release_rise_edge", last_rise - start, 6);
      check("rst_release_rise_count", rise_cnt - r0, 1);
      check("rst_release_level", {31'd0, pb_level}, 32'd1);

      // release from level 1
      pb_in = 1'b0;
      start = cyc;
      f0 = fall_cnt;
      tick(8);
      check("release_level", {31'd0, pb_level}, 32'd0);
`ifdef PB_DEBOUNCE_FALL_EN
      check("release_fall_edge", last_fall - start, 6);
      check("release_fall_count", fall_cnt - f0, 1);
`else
      check("release_fall_count", fall_cnt - f0, 0);
`endif

      // clean press
      pb_in = 1'b1;
      start = cyc;
      r0 = rise_cnt;
      tick(8);
      check("press_rise_edge", last_rise - start, 6);
      check("press_rise_count", rise_cnt - r0, 1);
      check("press_level", {31'd0, pb_level}, 32'd1);
      pb_in = 1'b0;
      tick(8);

      // bounce: 1,1,1,0 repeating never qualifies
      r0 = rise_cnt;
      for (int i = 0; i < 32; i++) begin
         pb_in = pat[i % 4];
         tick(1);
      end
      pb_in = 1'b0;
      tick(4);
      check("bounce_rise_count", rise_cnt - r0, 0);
      check("bounce_level", {31'd0, pb_level}, 32'd0);

      // boundary: 3 high samples -> nothing
      r0 = rise_cnt;
      pb_in = 1'b1;
      tick(3);
      pb_in = 1'b0;
      tick(8);
      check("boundary3_rise_count", rise_cnt - r0, 0);

      // boundary: 4 high samples -> rise
      r0 = rise_cnt;
      start = cyc;
      pb_in = 1'b1;
      tick(4);
      pb_in = 1'b0;
      tick(8);
      check("boundary4_rise_count", rise_cnt - r0, 1);
      check("boundary4_rise_edge", last_rise - start, 6);
      tick(8);
      check("boundary4_settle_level", {31'd0, pb_level}, 32'd0);

      // reset while counter is at 3 in WAIT_HIGH
      pb_in = 1'b1;
      tick(5);
      r0 = rise_cnt;
      reset_n = 1'b0;
      tick(1);
      check("midrst_level", {31'd0, pb_level}, 32'd0);
      reset_n = 1'b1;
      pb_in = 1'b0;
      tick(8);
      check("midrst_rise_count", rise_cnt - r0, 0);
      check("midrst_level_after", {31'd0, pb_level}, 32'd0);

      // randomized phase
      for (int s = 0; s < 400; s++) begin
         if ($urandom_range(0, 24) == 0) begin
            reset_n = 1'b0;
            tick($urandom_range(1, 2));
            reset_n = 1'b1;
         end else begin
            pb_in = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 8));
         end
      end
      pb_in = 1'b0;
      tick(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pb_debounce.md
# pb_debounce

Push-button conditioning stage: takes a raw asynchronous mechanical input, brings it into the `clk` domain through a two-flop synchronizer, then debounces it with a counter-qualified state machine. Outputs a clean level plus single-cycle rise/fall strobes. Sits between board-level switch pins and any control FSM that consumes button events.

## Interface
- `STABLE_CYCLES`, default 50000: consecutive synchronized samples that must disagree with the current level before the level changes. Legal range is 2 or more.
- `clk`  input  1  sole clock; all flops are rising-edge triggered.
- `reset_n`  input  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `pb_in`  input  1  raw asynchronous button input; may bounce or go metastable.
- `pb_level`  output  1  debounced level; registered.
- `rise_pulse`  output  1  one-cycle strobe when `pb_level` goes 0→1; registered.
- `fall_pulse`  output  1  one-cycle strobe when `pb_level` goes 1→0; registered. Only driven when `PB_DEBOUNCE_FALL_EN` is defined.

## Operation
- Synchronizer: `s1 <= pb_in`, `s2 <= s1`. Only `s2` is used downstream.
- Counter `cnt` is `$clog2(STABLE_CYCLES+1)` bits and is unsigned. It must never wrap.
- State machine states:
  - IDLE_LOW: `pb_level`=0, `cnt`=0. If `s2`=1, go to WAIT_HIGH with `cnt`=1.
  - WAIT_HIGH:
    - If `s2`=0, go to IDLE_LOW with `cnt`=0 (bounce rejected).
    - Else if `cnt`==STABLE_CYCLES-1, go to IDLE_HIGH with `pb_level`<=1, `rise_pulse`<=1, `cnt`<=0.
    - Else `cnt`++.
  - IDLE_HIGH: mirror of IDLE_LOW. `s2`=0 moves to WAIT_LOW with `cnt`=1.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - `s2`=1 returns to IDLE_HIGH.
    - Completion sets `pb_level`<=0 and `fall_pulse`<=1.
- Strobes are high for exactly one cycle and return to 0 on the next edge. `rise_pulse` and `fall_pulse` are never high together.
- Any single disagreeing-then-agreeing sample restarts qualification from zero. There is no partial credit.

## Timing
- Reset (`reset_n`=0 at an edge) sets:
  - `s1`=`s2`=0
  - state IDLE_LOW, `cnt`=0
  - `pb_level`=0, `rise_pulse`=0, `fall_pulse`=0
- Reset takes priority over every other transition, including mid-WAIT. Qualification progress is discarded.
- Latency: `pb_in` stable high from edge e0 (first edge sampling 1) gives `pb_level`=1 and `rise_pulse`=1 visible after edge e0+STABLE_CYCLES+1. That is STABLE_CYCLES+2 edges in total. Fall latency is identical.
- `pb_in` held high through reset release: treated as a fresh press. `rise_pulse` fires STABLE_CYCLES+2 edges after the first post-reset edge.
- Glitch shorter than STABLE_CYCLES cycles at `s2`: no change on any output.

## Configuration
- Macro `PB_DEBOUNCE_FALL_EN`.
- Defined: `fall_pulse` is registered as described above.
- Undefined: the `fall_pulse` register and its logic are omitted, and `fall_pulse` is tied to constant 0. The port list, state machine and `pb_level` behaviour are unchanged.

## Structure
- Package `pb_debounce_pkg` holds:
  - state typedef `db_state_t` (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW), 2-bit enum
  - localparam `DB_MIN_STABLE` = 2, with an elaboration-time check that `STABLE_CYCLES` is at least this value
- Sub-module `ff_sync2`: two-flop synchronizer.
  - Ports: `clk`, `reset_n`, `d`, `q`.
  - Synchronous active-low reset to 0.
  - Reusable by other async-input stages.

## Test plan
Bench uses `STABLE_CYCLES`=4.
- Reset behaviour: hold `reset_n`=0 for 3 cycles with `pb_in`=1 → all outputs 0. Release → `rise_pulse` for one cycle at edge 6 after release, and `pb_level`=1 from then on.
- Clean press: `pb_in` 0→1 and held → `pb_level` rises exactly 6 edges after the first sampling edge. `rise_pulse` is high for one cycle only.
- Bounce rejection: `pb_in` pattern 1,1,1,0,1,1,1,0 repeating → `pb_level` stays 0 and no strobes occur.
- Release: from `pb_level`=1, `pb_in`→0 held.
  - With `PB_DEBOUNCE_FALL_EN`: `fall_pulse` for one cycle 6 edges later and `pb_level`=0.
  - Without the macro: `fall_pulse` stays 0 throughout.
- Reset mid-qualification: assert `reset_n`=0 when `cnt`=3 in WAIT_HIGH → next edge gives state IDLE_LOW and `cnt`=0, with no `rise_pulse` emitted.
- Boundary: `pb_in` high for exactly 3 `s2` samples, then low → no change. High for exactly 4 samples → `rise_pulse` fires.
